// File: rtl/matriz_led_leitor_if.sv
// Matrix read-back bus: raw column/row lines in, decoded level and status out.
interface matriz_led_leitor_if;
  logic [4:0] COL;
  logic [6:0] ROW;
  logic [2:0] level;
  logic       level_valid;
  logic       frame_stb;
  logic       seq_err;
  logic       stale;

  modport master (
    output COL, ROW,
    input  level, level_valid, frame_stb, seq_err, stale
  );

  modport slave (
    input  COL, ROW,
    output level, level_valid, frame_stb, seq_err, stale
  );
endinterface

// File: rtl/matriz_led_leitor.sv
// Read-back monitor for the 5x7 level matrix: rebuilds scanned frames from the
// column/row lines, decodes the water level and flags scan faults and stalls.
//
// state   | meaning
// WAIT_C1 | idle, waiting for a column-1 capture
// CAP2..5 | slots 1..k-1 filled, expecting column k
// DECODE  | full frame held, one-cycle decode and confirm
module matriz_led_leitor #(
  parameter int STABLE_CYC     = 4,
  parameter int CONFIRM_FRAMES = 2,
  parameter int TIMEOUT_CYC    = 4096
) (
  input logic                clk,
  input logic                rst_n,
  matriz_led_leitor_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYC);
  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {WAIT_C1, CAP2, CAP3, CAP4, CAP5, DECODE} state_t;

  state_t          state, state_nxt;
  logic [4:0]      col_m, col_s, col_p;
  logic [6:0]      row_m, row_s;
  logic [SW-1:0]   stab_cnt;
  logic            fired;
  logic            capture, cap_single, cap_multi;
  logic [2:0]      col_idx;
  logic [6:0]      slot [5];
  logic            slot_we, frame_stb_c, seq_err_c;
  logic [2:0]      code, prev_code, level_q;
  logic            level_valid_q, stale_q, timed_out;
  logic [CW-1:0]   conf_cnt, conf_nxt;
  logic [TW-1:0]   to_cnt;

  function automatic logic [2:0] exp_col(input state_t s);
    case (s)
      CAP2:    return 3'd2;
      CAP3:    return 3'd3;
      CAP4:    return 3'd4;
      CAP5:    return 3'd5;
      default: return 3'd1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= '0;
      col_s <= '0;
      row_m <= '0;
      row_s <= '0;
    end else begin
      col_m <= bus.COL;
      col_s <= col_m;
      row_m <= bus.ROW;
      row_s <= row_m;
    end
  end

  // Down-counter loaded on every column change; one capture at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p    <= '0;
      stab_cnt <= '0;
      fired    <= 1'b0;
    end else begin
      col_p <= col_s;
      if (col_s != col_p) begin
        stab_cnt <= SW'(STABLE_CYC - 2);
        fired    <= 1'b0;
      end else if (stab_cnt != '0) begin
        stab_cnt <= stab_cnt - SW'(1);
      end else begin
        fired <= 1'b1;
      end
    end
  end

  assign capture = (col_s == col_p) && (stab_cnt == '0) && !fired;

  always_comb begin
    col_idx = 3'd0;
    case (col_s)
      5'b00001: col_idx = 3'd1;
      5'b00010: col_idx = 3'd2;
      5'b00100: col_idx = 3'd3;
      5'b01000: col_idx = 3'd4;
      5'b10000: col_idx = 3'd5;
      default:  col_idx = 3'd0;
    endcase
  end

  assign cap_single = capture && (col_idx != 3'd0);
  assign cap_multi  = capture && (col_s != 5'd0) && (col_idx == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_C1;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != DECODE && cap_multi) begin
      state_nxt = WAIT_C1;
    end else begin
      case (state)
        WAIT_C1: if (cap_single && col_idx == 3'd1) state_nxt = CAP2;
        DECODE:  state_nxt = WAIT_C1;
        default: begin
          if (cap_single) begin
            if (col_idx == exp_col(state))
              state_nxt = (state == CAP5) ? DECODE : state_t'(state + 3'd1);
            else if (col_idx == 3'd1)
              state_nxt = CAP2;
            else
              state_nxt = WAIT_C1;
          end
        end
      endcase
    end
  end

  always_comb begin
    frame_stb_c = (state == DECODE);
    seq_err_c   = 1'b0;
    slot_we     = 1'b0;
    if (state != DECODE) begin
      seq_err_c = cap_multi ||
                  (state != WAIT_C1 && cap_single && col_idx != exp_col(state));
      slot_we   = cap_single &&
                  (col_idx == 3'd1 || (state != WAIT_C1 && col_idx == exp_col(state)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) slot[i] <= '0;
    end else if (slot_we) begin
      slot[col_idx - 3'd1] <= row_s;
    end
  end

  always_comb begin
    code = 3'd7;
    if (slot[0] == slot[1] && slot[1] == slot[2] &&
        slot[2] == slot[3] && slot[3] == slot[4]) begin
      case (slot[0])
        7'h00:   code = 3'd0;
        7'h3F:   code = 3'd1;
        7'h37:   code = 3'd2;
        7'h36:   code = 3'd3;
        default: code = 3'd7;
      endcase
    end
  end

  always_comb begin
    if (code != prev_code)                        conf_nxt = CW'(1);
    else if (conf_cnt == CW'(CONFIRM_FRAMES))     conf_nxt = conf_cnt;
    else                                          conf_nxt = conf_cnt + CW'(1);
  end

  assign timed_out = (to_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code     <= 3'd0;
      conf_cnt      <= '0;
      level_q       <= 3'd0;
      level_valid_q <= 1'b0;
    end else if (frame_stb_c) begin
      prev_code <= code;
      conf_cnt  <= conf_nxt;
      if (conf_nxt == CW'(CONFIRM_FRAMES)) begin
        level_q       <= code;
        level_valid_q <= 1'b1;
      end
    end else if (timed_out) begin
      conf_cnt <= '0;
    end
  end

  // Any single-hot capture, including a column-1 restart, proves the scan is alive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      stale_q <= 1'b0;
    end else if (cap_single) begin
      to_cnt  <= '0;
      stale_q <= 1'b0;
    end else if (timed_out) begin
      stale_q <= 1'b1;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign bus.level       = level_q;
  assign bus.level_valid = level_valid_q;
  assign bus.frame_stb   = frame_stb_c;
  assign bus.seq_err     = seq_err_c;
  assign bus.stale       = stale_q;
endmodule

// File: tb/tb_matriz_led_leitor.sv
// Directed bench for the matrix read-back monitor: table of full frames plus
// hand sequences for order faults, glitches, latency, stall and reset.
module tb_matriz_led_leitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_frame = 0;
  int   n_seq = 0;
  int   f0, s0;

  matriz_led_leitor_if bus();

  matriz_led_leitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_stb) n_frame <= n_frame + 1;
    if (bus.seq_err)   n_seq   <= n_seq + 1;
  end

  typedef struct {
    logic [34:0] rows;
    int          exp_level;
    int          exp_valid;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] c, input logic [6:0] r, input int n);
    bus.COL = c;
    bus.ROW = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_frame(input logic [34:0] rows);
    for (int k = 0; k < 5; k++) begin
      drive(5'(1 << k), rows[7*k +: 7], 8);
      drive(5'd0, 7'd0, 2);
    end
  endtask

  function automatic logic [34:0] same(input logic [6:0] r);
    return {r, r, r, r, r};
  endfunction

  initial begin
    vecs[0]  = '{same(7'h3F), 0, 0};
    vecs[1]  = '{same(7'h3F), 1, 1};
    vecs[2]  = '{same(7'h3F), 1, 1};
    vecs[3]  = '{same(7'h37), 1, 1};
    vecs[4]  = '{same(7'h37), 2, 1};
    vecs[5]  = '{same(7'h36), 2, 1};
    vecs[6]  = '{same(7'h36), 3, 1};
    vecs[7]  = '{{7'h37, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 3, 1};
    vecs[8]  = '{{7'h37, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 7, 1};
    vecs[9]  = '{same(7'h00), 7, 1};
    vecs[10] = '{same(7'h00), 0, 1};

    bus.COL = 5'd0;
    bus.ROW = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", int'(bus.level), 0);
    check("rst_valid", int'(bus.level_valid), 0);
    check("rst_frame_stb", int'(bus.frame_stb), 0);
    check("rst_seq_err", int'(bus.seq_err), 0);
    check("rst_stale", int'(bus.stale), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 11; v++) begin
      f0 = n_frame;
      s0 = n_seq;
      scan_frame(vecs[v].rows);
      check($sformatf("vec%0d_level", v), int'(bus.level), vecs[v].exp_level);
      check($sformatf("vec%0d_valid", v), int'(bus.level_valid), vecs[v].exp_valid);
      check($sformatf("vec%0d_frames", v), n_frame - f0, 1);
      check($sformatf("vec%0d_seq", v), n_seq - s0, 0);
    end

    // Order fault C1, C2, C4 then a clean frame
    f0 = n_frame;
    s0 = n_seq;
    drive(5'b00001, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    drive(5'b00010, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    drive(5'b01000, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    check("order_seq", n_seq - s0, 1);
    check("order_frames", n_frame - f0, 0);
    scan_frame(same(7'h3F));
    check("order_recover_frames", n_frame - f0, 1);
    check("order_recover_seq", n_seq - s0, 1);
    check("order_recover_level", int'(bus.level), 0);

    // Short C3 glitch inside the C2 dwell
    f0 = n_frame;
    s0 = n_seq;
    drive(5'b00001, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    drive(5'b00010, 7'h3F, 2);
    drive(5'b00100, 7'h3F, 2);
    drive(5'b00010, 7'h3F, 6); drive(5'd0, 7'd0, 2);
    drive(5'b00100, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    drive(5'b01000, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    drive(5'b10000, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    check("glitch_seq", n_seq - s0, 0);
    check("glitch_frames", n_frame - f0, 1);
    check("glitch_level", int'(bus.level), 1);

    s0 = n_seq;
    f0 = n_frame;
    drive(5'b00101, 7'h3F, 6); drive(5'd0, 7'd0, 4);
    check("multihot_seq", n_seq - s0, 1);
    check("multihot_frames", n_frame - f0, 0);

    // Exact frame_stb and level timing relative to C5
    scan_frame(same(7'h36));
    check("lat_pre_level", int'(bus.level), 1);
    for (int k = 0; k < 4; k++) begin
      drive(5'(1 << k), 7'h36, 8);
      drive(5'd0, 7'd0, 2);
    end
    bus.COL = 5'b10000;
    bus.ROW = 7'h36;
    repeat (5) @(posedge clk);
    #1;
    check("lat_stb_early", int'(bus.frame_stb), 0);
    @(posedge clk);
    #1;
    check("lat_stb", int'(bus.frame_stb), 1);
    check("lat_level_old", int'(bus.level), 1);
    @(posedge clk);
    #1;
    check("lat_stb_end", int'(bus.frame_stb), 0);
    check("lat_level_new", int'(bus.level), 3);
    drive(5'b10000, 7'h36, 1);
    drive(5'd0, 7'd0, 2);

    // Stall: one new-code frame, then silence past the timeout
    scan_frame(same(7'h3F));
    check("stall_pre_level", int'(bus.level), 3);
    repeat (4000) @(posedge clk);
    #1;
    check("stall_early", int'(bus.stale), 0);
    repeat (150) @(posedge clk);
    #1;
    check("stall_stale", int'(bus.stale), 1);
    check("stall_level_held", int'(bus.level), 3);
    check("stall_valid_held", int'(bus.level_valid), 1);
    f0 = n_frame;
    drive(5'b00001, 7'h3F, 8);
    check("resume_stale", int'(bus.stale), 0);
    drive(5'd0, 7'd0, 2);
    for (int k = 1; k < 5; k++) begin
      drive(5'(1 << k), 7'h3F, 8);
      drive(5'd0, 7'd0, 2);
    end
    check("resume_frames", n_frame - f0, 1);
    check("resume_confirm_cleared", int'(bus.level), 3);
    scan_frame(same(7'h3F));
    check("resume_level", int'(bus.level), 1);

    // Asynchronous reset in the middle of a frame
    drive(5'b00001, 7'h3F, 8); drive(5'd0, 7'd0, 2);
    drive(5'b00010, 7'h3F, 4);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_level", int'(bus.level), 0);
    check("midrst_valid", int'(bus.level_valid), 0);
    check("midrst_frame_stb", int'(bus.frame_stb), 0);
    check("midrst_seq_err", int'(bus.seq_err), 0);
    check("midrst_stale", int'(bus.stale), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    f0 = n_frame;
    s0 = n_seq;
    drive(5'b00010, 7'h3F, 4); drive(5'd0, 7'd0, 2);
    for (int k = 2; k < 5; k++) begin
      drive(5'(1 << k), 7'h3F, 8);
      drive(5'd0, 7'd0, 2);
    end
    check("midrst_no_frame", n_frame - f0, 0);
    check("midrst_no_seq", n_seq - s0, 0);
    check("midrst_valid_after", int'(bus.level_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
